// File: rtl/alu_board_ctrl.sv
// Lab ALU board front-end: synchronised, debounced push-buttons load operands and
// op code from the switches; the registered ALU result and flags drive the LEDs.
module alu_board_ctrl #(
   parameter int N_DATA    = 8,
   parameter int N_OP      = 6,
   parameter int DB_CYCLES = 4
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [N_DATA-1:0] i_switch,
   input  logic [2:0]        i_buttons,
   output logic [N_DATA-1:0] o_led,
   output logic              o_carry,
   output logic              o_valid,
   output logic              o_op_invalid,
   output logic              o_multi_err
);

   localparam int CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0]     CNT_TC    = CW'(DB_CYCLES);
   localparam logic [N_DATA-1:0] SHIFT_LIM = N_DATA'(N_DATA);

   localparam logic [N_OP-1:0] C_ADD = N_OP'(6'b100000);
   localparam logic [N_OP-1:0] C_SUB = N_OP'(6'b100010);
   localparam logic [N_OP-1:0] C_AND = N_OP'(6'b100100);
   localparam logic [N_OP-1:0] C_OR  = N_OP'(6'b100101);
   localparam logic [N_OP-1:0] C_XOR = N_OP'(6'b100110);
   localparam logic [N_OP-1:0] C_NOR = N_OP'(6'b100111);
   localparam logic [N_OP-1:0] C_SRA = N_OP'(6'b000011);
   localparam logic [N_OP-1:0] C_SRL = N_OP'(6'b000010);

   logic [2:0]        sync1_q, sync2_q, db_q, db_d, db_prev_q;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [1:0]        prime_q;
   logic              armed_q;
   logic [N_DATA-1:0] a_q, b_q, res_q, res_d;
   logic [N_OP-1:0]   op_q;
   logic [2:0]        loaded_q;
   logic              carry_q, carry_d, err_q, op_inv;
   logic              rise, one_hot;

   always_comb begin
      cnt_d = cnt_q;
      db_d  = db_q;
      if (sync2_q == db_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_TC) begin
         db_d  = sync2_q;
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // armed_q blocks a button held through reset from counting as a fresh press
   assign rise    = armed_q && (db_prev_q == 3'b000) && (db_q != 3'b000);
   assign one_hot = ((db_q & (db_q - 3'd1)) == 3'b000);

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         db_q      <= '0;
         db_prev_q <= '0;
         cnt_q     <= '0;
         prime_q   <= '0;
         armed_q   <= 1'b0;
         a_q       <= '0;
         b_q       <= '0;
         op_q      <= '0;
         loaded_q  <= '0;
         err_q     <= 1'b0;
         res_q     <= '0;
         carry_q   <= 1'b0;
      end else begin
         sync1_q   <= i_buttons;
         sync2_q   <= sync1_q;
         db_q      <= db_d;
         db_prev_q <= db_q;
         cnt_q     <= cnt_d;
         prime_q   <= {prime_q[0], 1'b1};
         if (prime_q[1] && (sync2_q == 3'b000) && (db_q == 3'b000)) begin
            armed_q <= 1'b1;
         end
         if (rise && one_hot) begin
            if (db_q[2]) a_q  <= i_switch;
            if (db_q[1]) b_q  <= i_switch;
            if (db_q[0]) op_q <= i_switch[N_OP-1:0];
            loaded_q <= loaded_q | db_q;
         end
         if (rise && !one_hot) begin
            err_q <= 1'b1;
         end
         res_q   <= res_d;
         carry_q <= carry_d;
      end
   end

   always_comb begin
      res_d   = '0;
      carry_d = 1'b0;
      op_inv  = 1'b0;
      if (op_q == C_ADD) begin
         {carry_d, res_d} = {1'b0, a_q} + {1'b0, b_q};
      end else if (op_q == C_SUB) begin
         {carry_d, res_d} = {1'b0, a_q} - {1'b0, b_q};
      end else if (op_q == C_AND) begin
         res_d = a_q & b_q;
      end else if (op_q == C_OR) begin
         res_d = a_q | b_q;
      end else if (op_q == C_XOR) begin
         res_d = a_q ^ b_q;
      end else if (op_q == C_NOR) begin
         res_d = ~(a_q | b_q);
      end else if (op_q == C_SRA) begin
         res_d = (b_q >= SHIFT_LIM) ? {N_DATA{a_q[N_DATA-1]}} : N_DATA'($signed(a_q) >>> b_q);
      end else if (op_q == C_SRL) begin
         res_d = (b_q >= SHIFT_LIM) ? '0 : (a_q >> b_q);
      end else begin
         op_inv = 1'b1;
      end
   end

   assign o_led        = res_q;
   assign o_carry      = carry_q;
   assign o_valid      = &loaded_q;
   assign o_op_invalid = op_inv;
   assign o_multi_err  = err_q;

endmodule

// File: tb/tb_alu_board_ctrl.sv
// Self-checking bench for alu_board_ctrl: vector table of operand/op loads with a
// scoreboard queue, plus hand sequences for latency, bounce, multi-press and reset.
module tb_alu_board_ctrl;

   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] sw;
   logic [2:0] btn;
   logic [7:0] led;
   logic       carry, valid, op_inv, merr;

   int n_chk  = 0;
   int n_fail = 0;

   typedef struct {
      logic [7:0] led;
      logic       carry;
      logic       inv;
      logic       valid;
      logic       err;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [5:0] op;
      logic [7:0] led;
      logic       carry;
      logic       inv;
   } vec_t;

   exp_t exp_q[$];
   vec_t vecs[13];

   alu_board_ctrl #(.N_DATA(8), .N_OP(6), .DB_CYCLES(DB)) dut (
      .i_clk       (clk),
      .i_reset     (rst),
      .i_switch    (sw),
      .i_buttons   (btn),
      .o_led       (led),
      .o_carry     (carry),
      .o_valid     (valid),
      .o_op_invalid(op_inv),
      .o_multi_err (merr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] l, input logic c, input logic i,
                           input logic v, input logic e);
      exp_t x;
      x.led = l; x.carry = c; x.inv = i; x.valid = v; x.err = e;
      exp_q.push_back(x);
   endtask

   task automatic sb_check(input string nm);
      exp_t x;
      if (exp_q.size() == 0) begin
         n_chk++;
         n_fail++;
         $display("FAIL %s: scoreboard empty, got led %0h expected an entry", nm, led);
      end else begin
         x = exp_q.pop_front();
         chk({nm, ".led"},   32'(led),    32'(x.led));
         chk({nm, ".carry"}, 32'(carry),  32'(x.carry));
         chk({nm, ".inv"},   32'(op_inv), 32'(x.inv));
         chk({nm, ".valid"}, 32'(valid),  32'(x.valid));
         chk({nm, ".err"},   32'(merr),   32'(x.err));
      end
   endtask

   task automatic press(input logic [7:0] s, input logic [2:0] b, input int hold);
      @(negedge clk);
      sw  = s;
      btn = b;
      repeat (hold) @(negedge clk);
      btn = 3'b000;
      repeat (10) @(negedge clk);
   endtask

   initial begin
      int n;
      int changes;
      logic [7:0] prev;

      vecs[0]  = '{8'h05, 8'h07, 6'b100010, 8'hFE, 1'b1, 1'b0};
      vecs[1]  = '{8'h80, 8'h09, 6'b000011, 8'hFF, 1'b0, 1'b0};
      vecs[2]  = '{8'h80, 8'h09, 6'b000010, 8'h00, 1'b0, 1'b0};
      vecs[3]  = '{8'h0F, 8'h3C, 6'b100100, 8'h0C, 1'b0, 1'b0};
      vecs[4]  = '{8'h0F, 8'h3C, 6'b100101, 8'h3F, 1'b0, 1'b0};
      vecs[5]  = '{8'h0F, 8'h3C, 6'b100110, 8'h33, 1'b0, 1'b0};
      vecs[6]  = '{8'h0F, 8'h3C, 6'b100111, 8'hC0, 1'b0, 1'b0};
      vecs[7]  = '{8'h80, 8'h01, 6'b000011, 8'hC0, 1'b0, 1'b0};
      vecs[8]  = '{8'h80, 8'h07, 6'b000010, 8'h01, 1'b0, 1'b0};
      vecs[9]  = '{8'h10, 8'h10, 6'b100010, 8'h00, 1'b0, 1'b0};
      vecs[10] = '{8'hFF, 8'h01, 6'b100000, 8'h00, 1'b1, 1'b0};
      vecs[11] = '{8'h80, 8'h08, 6'b000011, 8'hFF, 1'b0, 1'b0};
      vecs[12] = '{8'h12, 8'h34, 6'b111111, 8'h00, 1'b0, 1'b1};

      rst = 1'b1;
      sw  = 8'h00;
      btn = 3'b000;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      push_exp(8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
      sb_check("reset_idle");

      // ADD with latency measurement on the op press
      press(8'hF0, 3'b100, 10);
      press(8'h20, 3'b010, 10);
      @(negedge clk);
      sw  = 8'h20;
      btn = 3'b001;
      n   = 0;
      while (n < 40) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         if (led != 8'h00) break;
      end
      chk("op_latency_edges", 32'(n - 1), 32'(DB + 4));
      repeat (5) @(negedge clk);
      btn = 3'b000;
      repeat (10) @(negedge clk);
      push_exp(8'h10, 1'b1, 1'b0, 1'b1, 1'b0);
      sb_check("add_f0_20");

      for (int i = 0; i < 13; i++) begin
         press(vecs[i].a, 3'b100, 10);
         press(vecs[i].b, 3'b010, 10);
         press({2'b00, vecs[i].op}, 3'b001, 10);
         push_exp(vecs[i].led, vecs[i].carry, vecs[i].inv, 1'b1, 1'b0);
         sb_check($sformatf("vec%0d", i));
      end

      // expose A on the LEDs with B=0, op=OR
      press(8'h00, 3'b010, 10);
      press(8'h25, 3'b001, 10);
      press(8'h5A, 3'b100, 10);
      push_exp(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0);
      sb_check("a_visible");

      @(negedge clk);
      sw = 8'h33;
      for (int r = 0; r < 5; r++) begin
         btn = 3'b100;
         repeat (DB - 1) @(negedge clk);
         btn = 3'b000;
         @(negedge clk);
      end
      repeat (10) @(negedge clk);
      chk("bounce_no_load", 32'(led), 32'h5A);

      btn     = 3'b100;
      changes = 0;
      prev    = led;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (led != prev) changes++;
         prev = led;
         if (i == DB + 6) sw = 8'h44;
      end
      btn = 3'b000;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (led != prev) changes++;
         prev = led;
      end
      chk("hold_single_load", 32'(changes), 32'd1);
      chk("hold_value", 32'(led), 32'h33);

      press(8'h99, 3'b110, 10);
      chk("multi_no_load", 32'(led), 32'h33);
      chk("multi_err_set", 32'(merr), 32'd1);
      press(8'h11, 3'b100, 10);
      push_exp(8'h11, 1'b0, 1'b0, 1'b1, 1'b1);
      sb_check("multi_err_sticky");

      // reset asserted mid-cycle while B is held
      @(negedge clk);
      sw  = 8'h77;
      btn = 3'b010;
      repeat (3) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("rst_async_led",   32'(led),   32'd0);
      chk("rst_async_carry", 32'(carry), 32'd0);
      chk("rst_async_valid", 32'(valid), 32'd0);
      chk("rst_async_err",   32'(merr),  32'd0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      btn = 3'b000;
      repeat (10) @(negedge clk);
      press(8'h01, 3'b100, 10);
      press(8'h25, 3'b001, 10);
      push_exp(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
      sb_check("held_b_ignored");
      press(8'h70, 3'b010, 10);
      push_exp(8'h71, 1'b0, 1'b0, 1'b1, 1'b0);
      sb_check("b_repress_loads");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
      $fatal(1);
   end

endmodule
